// File: rtl/draw_scheduler_if.sv
// Bus bundle between the segment requesters, the raster engine, the frame-buffer
// writer and the draw scheduler. The slave view is the scheduler; the master view
// is everything around it.
interface draw_scheduler_if #(
    parameter int COUNT_W = 16
);
    logic               abort;

    logic               req0_valid;
    logic               req0_ready;
    logic [9:0]         req0_x1, req0_y1, req0_x2, req0_y2;

    logic               req1_valid;
    logic               req1_ready;
    logic [9:0]         req1_x1, req1_y1, req1_x2, req1_y2;

    logic               eng_draw_enable;
    logic               eng_end_frame;
    logic               eng_renew_output;
    logic [9:0]         eng_x1, eng_y1, eng_x2, eng_y2;
    logic [9:0]         eng_x_pos, eng_y_pos;
    logic               eng_done;

    logic               pix_valid;
    logic               pix_ready;
    logic [9:0]         pix_x, pix_y;
    logic               pix_owner;

    logic               busy;
    logic [COUNT_W-1:0] seg_count;
    logic               err;

    modport slave (
        input  abort,
        input  req0_valid, req0_x1, req0_y1, req0_x2, req0_y2,
        output req0_ready,
        input  req1_valid, req1_x1, req1_y1, req1_x2, req1_y2,
        output req1_ready,
        output eng_draw_enable, eng_end_frame, eng_renew_output,
        output eng_x1, eng_y1, eng_x2, eng_y2,
        input  eng_x_pos, eng_y_pos, eng_done,
        output pix_valid, pix_x, pix_y, pix_owner,
        input  pix_ready,
        output busy, seg_count, err
    );

    modport master (
        output abort,
        output req0_valid, req0_x1, req0_y1, req0_x2, req0_y2,
        input  req0_ready,
        output req1_valid, req1_x1, req1_y1, req1_x2, req1_y2,
        input  req1_ready,
        input  eng_draw_enable, eng_end_frame, eng_renew_output,
        input  eng_x1, eng_y1, eng_x2, eng_y2,
        output eng_x_pos, eng_y_pos, eng_done,
        input  pix_valid, pix_x, pix_y, pix_owner,
        output pix_ready,
        input  busy, seg_count, err
    );
endinterface

// File: rtl/draw_scheduler.sv
// Draw scheduler: round-robin shares one line raster engine between two segment
// requesters, sequences the engine pulses (draw_enable, end_frame, renew_output)
// and streams each distinct generated pixel to the frame buffer over valid/ready.
module draw_scheduler #(
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_PIX       = 4095,
    parameter int COUNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    draw_scheduler_if.slave   bus
);
    localparam int PCW = $clog2(MAX_PIX + 1);
    localparam int SCW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_INIT, S_WAIT, S_EMIT, S_STEP, S_FINISH
    } state_t;

    state_t             state_q;
    logic [SCW-1:0]     cnt_q;
    logic [PCW-1:0]     pix_cnt_q;
    logic               last_grant_q;
    logic               owner_q;
    logic               first_q;
    logic               done_q;
    logic [19:0]        last_pos_q;
    logic [9:0]         eng_x1_q, eng_y1_q, eng_x2_q, eng_y2_q;
    logic               draw_en_q, end_frame_q, renew_q;
    logic               pix_valid_q;
    logic [9:0]         pix_x_q, pix_y_q;
    logic [COUNT_W-1:0] seg_count_q;
    logic               err_q;

    logic               take;
    logic               gnt1;
    logic [PCW-1:0]     pix_inc;
    logic [19:0]        cur_pos;
    logic               repeat_pos;

    // Arbitration and capture helpers; ready is only offered from IDLE outside reset/abort
    always_comb begin
        gnt1       = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
        take       = rst && !bus.abort && (state_q == S_IDLE) &&
                     (bus.req0_valid || bus.req1_valid);
        pix_inc    = pix_cnt_q + PCW'(1);
        cur_pos    = {bus.eng_x_pos, bus.eng_y_pos};
        repeat_pos = !first_q && (cur_pos == last_pos_q);
    end

    assign bus.req0_ready       = take && !gnt1;
    assign bus.req1_ready       = take && gnt1;
    assign bus.eng_draw_enable  = draw_en_q;
    assign bus.eng_end_frame    = end_frame_q;
    assign bus.eng_renew_output = renew_q;
    assign bus.eng_x1           = eng_x1_q;
    assign bus.eng_y1           = eng_y1_q;
    assign bus.eng_x2           = eng_x2_q;
    assign bus.eng_y2           = eng_y2_q;
    assign bus.pix_valid        = pix_valid_q;
    assign bus.pix_x            = pix_x_q;
    assign bus.pix_y            = pix_y_q;
    assign bus.pix_owner        = owner_q;
    assign bus.busy             = (state_q != S_IDLE);
    assign bus.seg_count        = seg_count_q;
    assign bus.err              = err_q;

    // Scheduler FSM with all outputs registered; pulses default low every cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            pix_cnt_q    <= '0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            first_q      <= 1'b1;
            done_q       <= 1'b0;
            last_pos_q   <= '0;
            eng_x1_q     <= '0;
            eng_y1_q     <= '0;
            eng_x2_q     <= '0;
            eng_y2_q     <= '0;
            draw_en_q    <= 1'b0;
            end_frame_q  <= 1'b0;
            renew_q      <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            seg_count_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            draw_en_q   <= 1'b0;
            end_frame_q <= 1'b0;
            renew_q     <= 1'b0;
            if (bus.abort) begin
                // A pixel accepted in the abort cycle is still counted as written
                state_q     <= S_IDLE;
                pix_valid_q <= 1'b0;
                if (state_q == S_EMIT && pix_valid_q && bus.pix_ready)
                    pix_cnt_q <= pix_inc;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (take) begin
                            eng_x1_q  <= gnt1 ? bus.req1_x1 : bus.req0_x1;
                            eng_y1_q  <= gnt1 ? bus.req1_y1 : bus.req0_y1;
                            eng_x2_q  <= gnt1 ? bus.req1_x2 : bus.req0_x2;
                            eng_y2_q  <= gnt1 ? bus.req1_y2 : bus.req0_y2;
                            owner_q   <= gnt1;
                            pix_cnt_q <= '0;
                            first_q   <= 1'b1;
                            draw_en_q <= 1'b1;
                            state_q   <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        cnt_q   <= SCW'(SETTLE_CYCLES);
                        state_q <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (cnt_q <= SCW'(1)) begin
                            end_frame_q <= 1'b1;
                            state_q     <= S_INIT;
                        end else begin
                            cnt_q <= cnt_q - SCW'(1);
                        end
                    end
                    S_INIT: begin
                        cnt_q   <= SCW'(SETTLE_CYCLES);
                        state_q <= S_WAIT;
                    end
                    S_WAIT, S_STEP: begin
                        // The renew pulse cycle itself does not count as settle time
                        if (renew_q) begin
                            cnt_q <= cnt_q;
                        end else if (cnt_q != '0) begin
                            cnt_q <= cnt_q - SCW'(1);
                        end else if (repeat_pos) begin
                            if (bus.eng_done) begin
                                state_q <= S_FINISH;
                            end else begin
                                renew_q <= 1'b1;
                                cnt_q   <= SCW'(SETTLE_CYCLES);
                                state_q <= S_STEP;
                            end
                        end else begin
                            pix_x_q     <= bus.eng_x_pos;
                            pix_y_q     <= bus.eng_y_pos;
                            pix_valid_q <= 1'b1;
                            done_q      <= bus.eng_done;
                            last_pos_q  <= cur_pos;
                            first_q     <= 1'b0;
                            state_q     <= S_EMIT;
                        end
                    end
                    S_EMIT: begin
                        if (bus.pix_ready) begin
                            pix_valid_q <= 1'b0;
                            pix_cnt_q   <= pix_inc;
                            if (done_q) begin
                                state_q <= S_FINISH;
                            end else if (pix_inc == PCW'(MAX_PIX)) begin
                                err_q   <= 1'b1;
                                state_q <= S_FINISH;
                            end else begin
                                renew_q <= 1'b1;
                                cnt_q   <= SCW'(SETTLE_CYCLES);
                                state_q <= S_STEP;
                            end
                        end
                    end
                    S_FINISH: begin
                        seg_count_q  <= seg_count_q + COUNT_W'(1);
                        last_grant_q <= owner_q;
                        pix_cnt_q    <= '0;
                        state_q      <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end
endmodule
